bcd_display_scanner: RTL and testbench

- Multi-digit time-multiplexing stage that sits directly upstream of the BCD-to-7-segment decoder.
- Holds NUM_DIGITS packed BCD digits and presents one digit at a time on bcd_out, which feeds the decoder.
- Drives the matching common-anode/cathode enable and decimal point, and rotates through the digits at a prescaled refresh rate.
- Double-buffers input digits so a frame never shows mixed old/new values.

---
 rtl/display_pkg.sv | 17 +
 rtl/bcd_display_scanner_if.sv | 26 ++
 rtl/bcd_display_scanner_scan_tick_gen.sv | 36 +++
 rtl/bcd_display_scanner.sv | 118 +++++++++++
 tb/tb_bcd_display_scanner.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed display path.
//   BCD_BLANK      - nibble value the segment decoder renders as all-off
//   cnt_width()    - register width needed to count 0..n-1 (minimum 1)
//   anode_off_bit()- level of one disabled anode bit for a given polarity
package display_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic anode_off_bit(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bus between a display-data producer (master) and the scanner (slave).
//   enable, load, digits_in, dp_in, lz_blank : producer -> scanner
//   bcd_out, anode, dp_out, frame_start      : scanner -> producer/pins
interface bcd_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_blank;
    logic [3:0]              bcd_out;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    dp_out;
    logic                    frame_start;

    modport master (
        output enable, load, digits_in, dp_in, lz_blank,
        input  bcd_out, anode, dp_out, frame_start
    );

    modport slave (
        input  enable, load, digits_in, dp_in, lz_blank,
        output bcd_out, anode, dp_out, frame_start
    );
endinterface

// File: rtl/bcd_display_scanner_scan_tick_gen.sv
// Slot prescaler: counts 0..CLK_DIV-1 while enabled, holds otherwise.
//   clk, rst  - clock, async active-high reset
//   enable    - count when 1, hold when 0
//   tick      - high in the wrap cycle (count == CLK_DIV-1 and enabled)
//   count_nxt - value the counter takes at the next edge; the scanner
//               registers its outputs from next state, so it compares this
module scan_tick_gen
    import display_pkg::*;
#(
    parameter int          CLK_DIV = 50000,
    parameter int unsigned CNT_W   = cnt_width(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             tick,
    output logic [CNT_W-1:0] count_nxt
);
    logic [CNT_W-1:0] count;

    always_comb begin
        tick      = enable && (count == CNT_W'(CLK_DIV - 1));
        count_nxt = count;
        if (enable) begin
            count_nxt = tick ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end
endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD digit scanner feeding a BCD-to-7-segment decoder.
//   clk, rst - clock, async active-high reset
//   bus      - slave side of bcd_display_scanner_if:
//              enable/load/digits_in/dp_in/lz_blank in,
//              bcd_out/anode/dp_out/frame_start out (all registered)
// Loads land in a shadow register; the shadow is copied to the active
// register only when the scan wraps to digit 0, so a frame is never torn.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 50000,
    parameter int BLANK_CYC        = 2,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input logic                clk,
    input logic                rst,
    bcd_display_scanner_if.slave bus
);
    localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);
    localparam int unsigned CNT_W = cnt_width(CLK_DIV);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        {NUM_DIGITS{anode_off_bit(ANODE_ACTIVE_LOW != 0)}};

    logic                    tick;
    logic [CNT_W-1:0]        count_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] shadow_dig, active_dig, active_dig_nxt;
    logic [NUM_DIGITS-1:0]   shadow_dp, active_dp, active_dp_nxt;
    logic [NUM_DIGITS-1:0]   sup, sel;
    logic                    run;
    logic [3:0]              bcd_d, bcd_q;
    logic [NUM_DIGITS-1:0]   anode_d, anode_q;
    logic                    dp_d, dp_q, fs_q;

    scan_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .enable    (bus.enable),
        .tick      (tick),
        .count_nxt (count_nxt)
    );

    always_comb begin
        wrap    = tick && (idx == IDX_W'(NUM_DIGITS - 1));
        idx_nxt = idx;
        if (tick) begin
            idx_nxt = wrap ? '0 : idx + 1'b1;
        end

        active_dig_nxt = active_dig;
        active_dp_nxt  = active_dp;
        if (wrap) begin
            // a load in the wrap cycle bypasses the shadow so it shows at once
            active_dig_nxt = bus.load ? bus.digits_in : shadow_dig;
            active_dp_nxt  = bus.load ? bus.dp_in     : shadow_dp;
        end

        // sup[i]: digits NUM_DIGITS-1 down to i are all zero; digit 0 exempt
        run = 1'b1;
        sup = '0;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            run = run & (active_dig_nxt[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            sup[NUM_DIGITS-1-k] = run;
        end

        sel          = '0;
        sel[idx_nxt] = 1'b1;

        anode_d = ANODE_OFF ^ sel;
        bcd_d   = (bus.lz_blank && sup[idx_nxt]) ? BCD_BLANK
                                                 : active_dig_nxt[{idx_nxt, 2'b00} +: 4];
        dp_d    = ~active_dp_nxt[idx_nxt];

        if (!bus.enable) begin
            anode_d = ANODE_OFF;
            bcd_d   = BCD_BLANK;
            dp_d    = 1'b1;
        end else if (count_nxt < CNT_W'(BLANK_CYC)) begin
            anode_d = ANODE_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            active_dig <= '0;
            active_dp  <= '0;
            bcd_q      <= BCD_BLANK;
            anode_q    <= ANODE_OFF;
            dp_q       <= 1'b1;
            fs_q       <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_dig <= bus.digits_in;
                shadow_dp  <= bus.dp_in;
            end
            idx        <= idx_nxt;
            active_dig <= active_dig_nxt;
            active_dp  <= active_dp_nxt;
            bcd_q      <= bcd_d;
            anode_q    <= anode_d;
            dp_q       <= dp_d;
            fs_q       <= wrap;
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.anode       = anode_q;
    assign bus.dp_out      = dp_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=4, CLK_DIV=4,
// BLANK_CYC=1, active-low anodes. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_bcd_display_scanner;
    logic clk = 1'b0;
    logic rst;
    int   n_checks;
    int   n_fail;

    bcd_display_scanner_if #(.NUM_DIGITS(4)) bus ();

    bcd_display_scanner #(
        .NUM_DIGITS       (4),
        .CLK_DIV          (4),
        .BLANK_CYC        (1),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] an_exp(input int s);
        case (s)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Entered on the falling edge at the start of slot s (blank cycle),
    // returns on the falling edge at the start of the following slot.
    // ld: 0 none, 1 load pulse in the slot's 2nd cycle, 2 load pulse in
    // the slot's last cycle (lands on the following edge).
    task automatic check_slot(input int s, input logic [3:0] ed, input logic edp,
                              input logic efs, input int ld, input logic [15:0] v);
        bus.load = 1'b0;
        chk("frame_start", {15'd0, bus.frame_start}, {15'd0, efs});
        chk("anode_blank", {12'd0, bus.anode}, 16'h000F);
        chk("bcd_blank", {12'd0, bus.bcd_out}, {12'd0, ed});
        @(negedge clk);
        chk("anode_on", {12'd0, bus.anode}, {12'd0, an_exp(s)});
        chk("bcd_on", {12'd0, bus.bcd_out}, {12'd0, ed});
        chk("dp_out", {15'd0, bus.dp_out}, {15'd0, edp});
        if (ld == 1) begin
            bus.load      = 1'b1;
            bus.digits_in = v;
        end
        @(negedge clk);
        bus.load = 1'b0;
        chk("frame_start_low", {15'd0, bus.frame_start}, 16'd0);
        @(negedge clk);
        if (ld == 2) begin
            bus.load      = 1'b1;
            bus.digits_in = v;
        end
        @(negedge clk);
    endtask

    task automatic wait_fs();
        int cnt;
        cnt = 0;
        while (bus.frame_start !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            bus.load = 1'b0;
            cnt++;
        end
        chk("fs_latency", 16'(cnt), 16'd16);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        bus.lz_blank  = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_anode", {12'd0, bus.anode}, 16'h000F);
        chk("rst_bcd", {12'd0, bus.bcd_out}, 16'h000F);
        chk("rst_dp", {15'd0, bus.dp_out}, 16'd1);
        chk("rst_fs", {15'd0, bus.frame_start}, 16'd0);

        // release, load 1234 and start scanning
        rst           = 1'b0;
        bus.load      = 1'b1;
        bus.digits_in = 16'h1234;
        bus.enable    = 1'b1;
        wait_fs();

        // frame A: 4,3,2,1
        check_slot(0, 4'h4, 1'b1, 1'b1, 0, 16'h0);
        check_slot(1, 4'h3, 1'b1, 1'b0, 0, 16'h0);
        check_slot(2, 4'h2, 1'b1, 1'b0, 0, 16'h0);
        check_slot(3, 4'h1, 1'b1, 1'b0, 0, 16'h0);
        // frame B: load 5678 during idx=2, frame finishes with old data
        check_slot(0, 4'h4, 1'b1, 1'b1, 0, 16'h0);
        check_slot(1, 4'h3, 1'b1, 1'b0, 0, 16'h0);
        check_slot(2, 4'h2, 1'b1, 1'b0, 1, 16'h5678);
        check_slot(3, 4'h1, 1'b1, 1'b0, 0, 16'h0);
        // frame C: 8,7,6,5; load 9999 in the wrap cycle
        check_slot(0, 4'h8, 1'b1, 1'b1, 0, 16'h0);
        check_slot(1, 4'h7, 1'b1, 1'b0, 0, 16'h0);
        check_slot(2, 4'h6, 1'b1, 1'b0, 0, 16'h0);
        check_slot(3, 4'h5, 1'b1, 1'b0, 2, 16'h9999);
        // frame D: same-cycle load already visible; queue 0040, enable lz
        check_slot(0, 4'h9, 1'b1, 1'b1, 0, 16'h0);
        check_slot(1, 4'h9, 1'b1, 1'b0, 1, 16'h0040);
        bus.lz_blank = 1'b1;
        check_slot(2, 4'h9, 1'b1, 1'b0, 0, 16'h0);
        check_slot(3, 4'h9, 1'b1, 1'b0, 0, 16'h0);
        // frame E: 0040 with lz -> 0,4,F,F; queue 0000
        check_slot(0, 4'h0, 1'b1, 1'b1, 0, 16'h0);
        check_slot(1, 4'h4, 1'b1, 1'b0, 1, 16'h0000);
        check_slot(2, 4'hF, 1'b1, 1'b0, 0, 16'h0);
        check_slot(3, 4'hF, 1'b1, 1'b0, 0, 16'h0);
        // frame F: 0000 with lz -> 0,F,F,F; queue 0040
        check_slot(0, 4'h0, 1'b1, 1'b1, 0, 16'h0);
        check_slot(1, 4'hF, 1'b1, 1'b0, 1, 16'h0040);
        check_slot(2, 4'hF, 1'b1, 1'b0, 0, 16'h0);
        check_slot(3, 4'hF, 1'b1, 1'b0, 0, 16'h0);
        bus.lz_blank = 1'b0;
        // frame G: 0040 without lz -> 0,4,0,0; queue 4321 with dp on digit 2
        check_slot(0, 4'h0, 1'b1, 1'b1, 0, 16'h0);
        bus.dp_in = 4'b0100;
        check_slot(1, 4'h4, 1'b1, 1'b0, 1, 16'h4321);
        check_slot(2, 4'h0, 1'b1, 1'b0, 0, 16'h0);
        check_slot(3, 4'h0, 1'b1, 1'b0, 0, 16'h0);
        // frame H: 1,2,3,4 with dp lit only on digit 2; pause inside slot 2
        check_slot(0, 4'h1, 1'b1, 1'b1, 0, 16'h0);
        check_slot(1, 4'h2, 1'b1, 1'b0, 0, 16'h0);
        chk("h2_blank_anode", {12'd0, bus.anode}, 16'h000F);
        chk("h2_blank_bcd", {12'd0, bus.bcd_out}, 16'h0003);
        @(negedge clk);
        chk("h2_anode", {12'd0, bus.anode}, 16'h000B);
        chk("h2_dp", {15'd0, bus.dp_out}, 16'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("dis_anode", {12'd0, bus.anode}, 16'h000F);
        chk("dis_bcd", {12'd0, bus.bcd_out}, 16'h000F);
        chk("dis_dp", {15'd0, bus.dp_out}, 16'd1);
        repeat (5) @(negedge clk);
        chk("dis_hold_anode", {12'd0, bus.anode}, 16'h000F);
        chk("dis_hold_fs", {15'd0, bus.frame_start}, 16'd0);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("resume_anode", {12'd0, bus.anode}, 16'h000B);
        chk("resume_bcd", {12'd0, bus.bcd_out}, 16'h0003);
        chk("resume_dp", {15'd0, bus.dp_out}, 16'd0);
        @(negedge clk);
        chk("resume_anode2", {12'd0, bus.anode}, 16'h000B);
        @(negedge clk);
        check_slot(3, 4'h4, 1'b1, 1'b0, 0, 16'h0);

        // frame I: async reset in the middle of digit-0 slot
        @(negedge clk);
        chk("pre_rst_anode", {12'd0, bus.anode}, 16'h000E);
        chk("pre_rst_bcd", {12'd0, bus.bcd_out}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        chk("async_anode", {12'd0, bus.anode}, 16'h000F);
        chk("async_bcd", {12'd0, bus.bcd_out}, 16'h000F);
        chk("async_dp", {15'd0, bus.dp_out}, 16'd1);
        chk("async_fs", {15'd0, bus.frame_start}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_fs();
        check_slot(0, 4'h0, 1'b1, 1'b1, 0, 16'h0);
        check_slot(1, 4'h0, 1'b1, 1'b0, 0, 16'h0);
        check_slot(2, 4'h0, 1'b1, 1'b0, 0, 16'h0);
        check_slot(3, 4'h0, 1'b1, 1'b0, 0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
